// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends PATTERN MSB first, count times, with GAP idle cycles between.
// Define SEQ_GEN_PARITY_EN to append an odd-parity bit after every pattern instance.
module seq_gen #(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10001,
  parameter int unsigned      GAP     = 2,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      IDX_W  = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IdxTop = IDX_W'(PAT_W - 1);
  localparam int unsigned      GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GapTop = GAP_W'((GAP > 0) ? GAP - 1 : 0);

`ifdef SEQ_GEN_PARITY_EN
  typedef enum logic [1:0] {StIdle, StSend, StGap, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;
`endif

  state_e           state_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] rep_left_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic [IDX_W-1:0] idx_next;
  logic             rep_end;

  // rep_end marks the cycle carrying the last bit of a repetition (pattern or parity).
  always_comb begin
    idx_next = bit_idx_q - 1'b1;
`ifdef SEQ_GEN_PARITY_EN
    rep_end  = (state_q == StParity);
`else
    rep_end  = (state_q == StSend) && (bit_idx_q == '0);
`endif
  end

  // Outputs are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_idx_q  <= '0;
      rep_left_q <= '0;
      gap_cnt_q  <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rep_end) begin
        if (rep_left_q > CNT_W'(1)) begin
          rep_left_q <= rep_left_q - 1'b1;
          bit_idx_q  <= IdxTop;
          if (GAP > 0) begin
            state_q   <= StGap;
            gap_cnt_q <= GapTop;
            out       <= 1'b0;
            out_valid <= 1'b0;
          end else begin
            state_q   <= StSend;
            out       <= PATTERN[IdxTop];
            out_valid <= 1'b1;
          end
        end else begin
          state_q   <= StIdle;
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
      end else begin
        case (state_q)
          StIdle: begin
            if (start && (count != '0)) begin
              state_q    <= StSend;
              rep_left_q <= count;
              bit_idx_q  <= IdxTop;
              out        <= PATTERN[IdxTop];
              out_valid  <= 1'b1;
              busy       <= 1'b1;
            end
          end
          StSend: begin
            if (bit_idx_q != '0) begin
              bit_idx_q <= idx_next;
              out       <= PATTERN[idx_next];
            end else begin
`ifdef SEQ_GEN_PARITY_EN
              state_q <= StParity;
              out     <= ~^PATTERN;
`else
              state_q <= StIdle;
`endif
            end
          end
          StGap: begin
            if (gap_cnt_q == '0) begin
              state_q   <= StSend;
              bit_idx_q <= IdxTop;
              out       <= PATTERN[IdxTop];
              out_valid <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_q - 1'b1;
            end
          end
          default: begin
            state_q   <= StIdle;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: per-cycle comparison against a stream model built from the
// transfer rules, plus a sliding-window 10001 detector on the serial output.
module tb_seq_gen;

  localparam int unsigned PAT_W   = 5;
  localparam logic [4:0]  PATTERN = 5'b10001;
  localparam int unsigned GAP     = 2;
  localparam int unsigned CNT_W   = 8;
`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             out, out_valid, busy, done;
  logic             out0, out_valid0, busy0, done0;

  int checks   = 0;
  int failures = 0;

  // Expected per-cycle {out, out_valid, busy, done}, starting the cycle after start is taken.
  logic [3:0]       exp_q[$];
  logic [3:0]       obs;
  logic [PAT_W-1:0] win;
  int               fires, busy_n, done_n, valid_n;

  seq_gen #(.PAT_W(PAT_W), .PATTERN(PATTERN), .GAP(GAP), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  seq_gen #(.PAT_W(PAT_W), .PATTERN(PATTERN), .GAP(0), .CNT_W(CNT_W)) u_dut_gap0 (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .out(out0), .out_valid(out_valid0), .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  function automatic void build(input int unsigned n, input int unsigned gap);
    exp_q.delete();
    for (int r = 0; r < int'(n); r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({PATTERN[i], 3'b110});
      if (P == 1) exp_q.push_back({~^PATTERN, 3'b110});
      if (r != int'(n) - 1)
        for (int g = 0; g < int'(gap); g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; count = 8'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({out, out_valid, busy, done} !== 4'b0000 || {out0, out_valid0, busy0, done0} !== 4'b0000)
      begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %b/%b expected 0000", i,
                 {out, out_valid, busy, done}, {out0, out_valid0, busy0, done0});
      end
    end
    reset = 1'b1; start = 1'b0;
    step();
    checks++;
    if ({out, out_valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle: got %b expected 0000", {out, out_valid, busy, done});
    end
  endtask

  task automatic test_gap0();
    build(2, 0);
    valid_n = 0;
    count = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) step();
      obs = {out0, out_valid0, busy0, done0};
      valid_n += int'(out_valid0);
      checks++;
      if (obs !== exp_q[c]) begin
        failures++;
        $display("FAIL gap0 cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
    end
    checks++;
    if (valid_n != 2 * int'(PAT_W + P)) begin
      failures++;
      $display("FAIL gap0_valid_len: got %0d expected %0d", valid_n, 2 * (PAT_W + P));
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_single();
    build(1, GAP);
    win = '0; fires = 0; busy_n = 0;
    count = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) step();
      obs = {out, out_valid, busy, done};
      win = {win[PAT_W-2:0], out};
      if (win == PATTERN) fires++;
      busy_n += int'(busy);
      checks++;
      if (obs !== exp_q[c]) begin
        failures++;
        $display("FAIL single cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
    end
    checks++;
    if (fires != 1 || busy_n != int'(PAT_W + P)) begin
      failures++;
      $display("FAIL single_summary: fires=%0d busy=%0d expected fires=1 busy=%0d",
               fires, busy_n, PAT_W + P);
    end
  endtask

  task automatic test_multi();
    build(3, GAP);
    win = '0; fires = 0; busy_n = 0; done_n = 0;
    count = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) step();
      obs = {out, out_valid, busy, done};
      win = {win[PAT_W-2:0], out};
      if (win == PATTERN) fires++;
      busy_n += int'(busy);
      done_n += int'(done);
      checks++;
      if (obs !== exp_q[c]) begin
        failures++;
        $display("FAIL multi cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
    end
    checks++;
    if (fires != 3 || done_n != 1 || busy_n != 3 * int'(PAT_W + P) + 2 * int'(GAP)) begin
      failures++;
      $display("FAIL multi_summary: fires=%0d done=%0d busy=%0d expected 3/1/%0d",
               fires, done_n, busy_n, 3 * (PAT_W + P) + 2 * GAP);
    end
  endtask

  task automatic test_ignore();
    count = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out, out_valid, busy, done} !== 4'b0000) begin
        failures++;
        $display("FAIL count0 cycle %0d: got %b expected 0000", i, {out, out_valid, busy, done});
      end
      step();
    end
    build(2, GAP);
    count = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) step();
      obs = {out, out_valid, busy, done};
      checks++;
      if (obs !== exp_q[c]) begin
        failures++;
        $display("FAIL ignore_busy cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
      start = (c >= 1 && c <= 2);
      count = 8'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    int abort_at;
    abort_at = int'(PAT_W + P + GAP) + int'(PAT_W) - 1 - 2;
    build(3, GAP);
    count = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c <= abort_at; c++) begin
      if (c > 0) step();
      obs = {out, out_valid, busy, done};
      checks++;
      if (obs !== exp_q[c]) begin
        failures++;
        $display("FAIL abort_pre cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out, out_valid, busy, done} !== 4'b0000) begin
        failures++;
        $display("FAIL abort_post cycle %0d: got %b expected 0000", i,
                 {out, out_valid, busy, done});
      end
      step();
    end
    build(1, GAP);
    count = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) step();
      obs = {out, out_valid, busy, done};
      checks++;
      if (obs !== exp_q[c]) begin
        failures++;
        $display("FAIL abort_restart cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] second_q[$];
    build(1, GAP);
    second_q = exp_q;
    build(2, GAP);
    void'(exp_q.pop_back());
    count = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) step();
      obs = {out, out_valid, busy, done};
      checks++;
      if (obs !== exp_q[c]) begin
        failures++;
        $display("FAIL b2b_first cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
    end
    count = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < second_q.size(); c++) begin
      if (c > 0) step();
      obs = {out, out_valid, busy, done};
      checks++;
      if (obs !== second_q[c]) begin
        failures++;
        $display("FAIL b2b_second cycle %0d: got %b expected %b", c, obs, second_q[c]);
      end
    end
  endtask

  task automatic test_max_count();
    int n;
    n = (1 << CNT_W) - 1;
    build(n, GAP);
    busy_n = 0; done_n = 0;
    count = CNT_W'(n); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) step();
      obs = {out, out_valid, busy, done};
      busy_n += int'(busy);
      done_n += int'(done);
      checks++;
      if (obs !== exp_q[c]) begin
        failures++;
        $display("FAIL max_count cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
    end
    checks++;
    if (done_n != 1 || busy_n != n * int'(PAT_W + P) + (n - 1) * int'(GAP)) begin
      failures++;
      $display("FAIL max_count_summary: done=%0d busy=%0d expected 1/%0d", done_n, busy_n,
               n * int'(PAT_W + P) + (n - 1) * int'(GAP));
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 25; it++) begin
      n = int'($urandom_range(1, 6));
      build(n, GAP);
      count = CNT_W'(n); start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < exp_q.size(); c++) begin
        if (c > 0) step();
        obs = {out, out_valid, busy, done};
        checks++;
        if (obs !== exp_q[c]) begin
          failures++;
          $display("FAIL random it %0d n %0d cycle %0d: got %b expected %b", it, n, c, obs,
                   exp_q[c]);
        end
        // Noise on start/count while busy; quiet from the done cycle on.
        start = (c < exp_q.size() - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        count = 8'($urandom);
      end
      start = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; count = '0;
    test_reset();
    test_gap0();
    test_single();
    test_multi();
    test_ignore();
    test_abort();
    test_back_to_back();
    test_max_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter that drives a single-bit stream containing a fixed PAT_W-bit pattern (default 1-0-0-0-1, MSB first), repeated a requested number of times with idle gaps between repetitions. It is the source side of our serial sequence-detector FSMs: its `out` port connects directly to a detector's `in` port for stimulus generation and loopback checks. All outputs are registered, and it runs in the detectors' clock domain.

## Interface
- PAT_W, 5: pattern length in bits (≥2).
- PATTERN, 5'b10001: pattern sent MSB first.
- GAP, 2: idle cycles between repetitions (0 allowed).
- CNT_W, 8: width of repetition count.

- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled only on rising clk.
- start  input  1  request; sampled only in IDLE.
- count  input  CNT_W  repetitions; sampled with start.
- out  output  1  serial data bit.
- out_valid  output  1  high while `out` carries a pattern (or parity) bit.
- busy  output  1  high from the first transmitted bit through the last bit.
- done  output  1  one-cycle pulse after the final bit.

## Operation
- States: IDLE, SEND, GAP, and PARITY (present only with the macro). Internal registers: bit_idx (pattern index) and rep_left (CNT_W bits).
- Reset (reset==0 at a clk edge): state=IDLE and out=0, out_valid=0, busy=0, done=0. Reset overrides every other input.
- IDLE: out=0, out_valid=0, busy=0.
  - On start==1 with count!=0: latch rep_left=count, set bit_idx=PAT_W-1, go to SEND.
  - start==1 with count==0 is ignored: no busy, no done.
- SEND:
  - Each cycle drives out=PATTERN[bit_idx], out_valid=1, busy=1, then decrements bit_idx.
  - After bit 0: go to PARITY if enabled, otherwise go to the end-of-repetition decision.
- End of repetition:
  - If rep_left>1: decrement rep_left, reload bit_idx. Go to GAP if GAP>0, else straight to SEND with no bubble.
  - If rep_left==1: go to IDLE and assert done for exactly one cycle.
- GAP: out=0, out_valid=0, busy=1 for exactly GAP cycles, then SEND.
- start is ignored whenever state≠IDLE; count changes during busy have no effect.
- Reset mid-operation aborts the transfer. No done is issued and no partial state is retained.

## Timing
- start sampled high at edge k (IDLE): the first bit is visible after edge k, in cycle k+1.
- busy high for count·(PAT_W+P) + (count−1)·GAP cycles, where P=1 with parity and 0 without.
- done is high in the first IDLE cycle after the last bit; busy=0 in that cycle.
- A start asserted in the done cycle is accepted, and the next transfer's first bit follows immediately. The gap between transfers is then exactly one cycle with out_valid=0.
- rep_left never wraps: count=2^CNT_W−1 sends exactly that many repetitions.

## Configuration
- SEQ_GEN_PARITY_EN defined:
  - After each pattern instance, one PARITY cycle drives out = ~^PATTERN (odd parity over the pattern), with out_valid=1, busy=1.
  - The GAP/IDLE decision follows the parity cycle.
- Undefined: the PARITY state and its logic are absent, and repetitions consist of the PAT_W pattern bits only.

## Test plan
- Reset low 2 cycles, then start=1, count=1, defaults → out=1,0,0,0,1 with out_valid=1 for 5 cycles, busy 5 cycles, done pulse in cycle 6. A connected 10001 detector fires once, on the final bit.
- count=3, GAP=2 → stream 10001 00 10001 00 10001: out_valid low only on the 4 gap cycles, busy 19 cycles, one done pulse, and the detector fires 3 times.
- start pulsed during SEND, plus a start with count=0 in IDLE → both ignored: busy and done unaffected, no bits emitted.
- reset driven low while bit_idx=2 of repetition 2 → next cycle out=0, out_valid=0, busy=0, no done. A later start with count=1 produces a clean 10001.
- GAP=0, count=2 → 1000110001 with out_valid continuously high for 10 cycles.
- SEQ_GEN_PARITY_EN, count=1 → out=1,0,0,0,1,1 (parity bit 1) with out_valid high 6 cycles and done in cycle 7. A start in the done cycle → new first bit in the following cycle.
